// File: rtl/ntt_cmd_sequencer_pkg.sv
// Shared opcodes, payload modes and FSM encoding for the NTT command sequencer.
package ntt_cmd_sequencer_pkg;

    // Core opcodes pulsed on OP_CODE for one cycle at the start of a command.
    localparam logic [4:0] OP_LD_PAR  = 5'b00001;
    localparam logic [4:0] OP_LD_W    = 5'b00010;
    localparam logic [4:0] OP_LD_DATA = 5'b00011;
    localparam logic [4:0] OP_NTT     = 5'b00100;
    localparam logic [4:0] OP_INTT    = 5'b00111;
    localparam logic [4:0] OP_RD      = 5'b01000;
    localparam logic [4:0] OP_LD_WINV = 5'b01010;
    localparam logic [4:0] OP_PWM     = 5'b01100;

    // Payload phase behaviour selected by cmd_mode.
    localparam logic [1:0] MODE_STREAM    = 2'd0;
    localparam logic [1:0] MODE_HOLD      = 2'd1;
    localparam logic [1:0] MODE_WAIT      = 2'd2;
    localparam logic [1:0] MODE_WAIT_DONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_TRAIL     = 3'd6
    } seq_state_t;

    // State entered after ISSUE. A zero length skips the payload phase,
    // except WAIT_DONE, whose length is meaningless.
    function automatic seq_state_t payload_state(input logic [1:0] mode,
                                                 input logic       len_zero);
        seq_state_t st;
        st = ST_TRAIL;
        if (mode == MODE_WAIT_DONE) begin
            st = ST_WAIT_DONE;
        end else if (!len_zero) begin
            case (mode)
                MODE_STREAM: st = ST_STREAM;
                MODE_HOLD:   st = ST_HOLD;
                default:     st = ST_WAIT;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/ntt_cmd_sequencer.sv
// Command-driven sequencer feeding OP_CODE/din_valid/din0 of the NTT1024 core.
// Each command: one-cycle opcode pulse, a payload phase, one idle trailer cycle.
module ntt_cmd_sequencer
    import ntt_cmd_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [1:0]        cmd_mode,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    input  logic              core_done,
    output logic [OP_W-1:0]   OP_CODE,
    output logic              din_valid,
    output logic [DATA_W-1:0] din0,
    output logic              busy,
    output logic              cmd_done,
    output logic              err
);

    // Timeout counter counts WAIT_DONE cycles 0..TIMEOUT-1.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    seq_state_t        state_reg,     state_next;
    logic [1:0]        mode_reg,      mode_next;
    logic [LEN_W-1:0]  len_reg,       len_next;
    logic [LEN_W-1:0]  cnt_reg,       cnt_next;
    logic [TMO_W-1:0]  tmo_reg,       tmo_next;
    logic [OP_W-1:0]   op_code_reg,   op_code_next;
    logic              din_valid_reg, din_valid_next;
    logic [DATA_W-1:0] din0_reg,      din0_next;
    logic              cmd_done_reg,  cmd_done_next;
    logic              err_reg,       err_next;

    logic [LEN_W-1:0]  cnt_inc;
    logic              word_take;

    // Handshake signals depend on state only, so they are stable all cycle.
    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign src_ready = (state_reg == ST_STREAM) && (cnt_reg != len_reg);
    assign word_take = src_ready && src_valid;
    assign cnt_inc   = cnt_reg + LEN_W'(1);

    // Core-facing outputs come straight from registers.
    assign OP_CODE   = op_code_reg;
    assign din_valid = din_valid_reg;
    assign din0      = din0_reg;
    assign cmd_done  = cmd_done_reg;
    assign err       = err_reg;

    // Next-state and next-output logic; outputs are aligned with the state they belong to.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        tmo_next       = tmo_reg;
        op_code_next   = '0;
        din_valid_next = 1'b0;
        din0_next      = din0_reg;
        err_next       = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_next    = cmd_mode;
                    len_next     = cmd_len;
                    op_code_next = cmd_op;
                    cnt_next     = '0;
                    tmo_next     = '0;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = payload_state(mode_reg, len_reg == '0);
            end
            ST_STREAM: begin
                // A word accepted now is presented to the core next cycle, so the
                // state lingers one cycle after the last accept to show it.
                if (word_take) begin
                    din_valid_next = 1'b1;
                    din0_next      = src_data;
                    cnt_next       = cnt_inc;
                end else if (cnt_reg == len_reg) begin
                    state_next = ST_TRAIL;
                end
            end
            ST_HOLD, ST_WAIT: begin
                cnt_next = cnt_inc;
                if (cnt_inc == len_reg) begin
                    state_next = ST_TRAIL;
                end
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    state_next = ST_TRAIL;
                end else if (tmo_reg == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_TRAIL;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            ST_TRAIL: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // HOLD drives din_valid for every cycle spent in it; TRAIL carries cmd_done.
        if (state_next == ST_HOLD) begin
            din_valid_next = 1'b1;
        end
        cmd_done_next = (state_next == ST_TRAIL);
    end

    // State and output registers; reset aborts any command in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_STREAM;
            len_reg       <= '0;
            cnt_reg       <= '0;
            tmo_reg       <= '0;
            op_code_reg   <= '0;
            din_valid_reg <= 1'b0;
            din0_reg      <= '0;
            cmd_done_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            tmo_reg       <= tmo_next;
            op_code_reg   <= op_code_next;
            din_valid_reg <= din_valid_next;
            din0_reg      <= din0_next;
            cmd_done_reg  <= cmd_done_next;
            err_reg       <= err_next;
        end
    end

endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// Directed bench for ntt_cmd_sequencer: stream, stalls, hold, waits, timeout, async reset.
module tb_ntt_cmd_sequencer;
    import ntt_cmd_sequencer_pkg::*;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 5;
    localparam int LEN_W   = 12;
    localparam int TIMEOUT = 64;
    localparam int TR_MAX  = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op = '0;
    logic [1:0]        cmd_mode = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic [DATA_W-1:0] src_data = '0;
    logic              core_done = 1'b0;
    logic [OP_W-1:0]   OP_CODE;
    logic              din_valid;
    logic [DATA_W-1:0] din0;
    logic              busy;
    logic              cmd_done;
    logic              err;

    ntt_cmd_sequencer #(
        .DATA_W(DATA_W), .OP_W(OP_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .core_done(core_done),
        .OP_CODE(OP_CODE), .din_valid(din_valid), .din0(din0),
        .busy(busy), .cmd_done(cmd_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Trace of the cycles following ISSUE, up to and including the cmd_done cycle.
    logic              tr_dv   [0:TR_MAX-1];
    logic [DATA_W-1:0] tr_d0   [0:TR_MAX-1];
    logic              tr_done [0:TR_MAX-1];
    logic              tr_err  [0:TR_MAX-1];
    logic [OP_W-1:0]   tr_op   [0:TR_MAX-1];
    int                tr_len;
    int                widx;
    logic [DATA_W-1:0] words [0:3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_at(input int i);
        if (i < 4) return words[i];
        return DATA_W'(32'h0001_0000 + i);
    endfunction

    function automatic int count_dv();
        int n = 0;
        for (int c = 0; c < tr_len; c++) if (tr_dv[c]) n++;
        return n;
    endfunction

    function automatic int count_op();
        int n = 0;
        for (int c = 0; c < tr_len; c++) if (tr_op[c] != '0) n++;
        return n;
    endfunction

    function automatic logic [31:0] pack_dv();
        logic [31:0] v = '0;
        for (int c = 0; c < tr_len && c < 32; c++) v[c] = tr_dv[c];
        return v;
    endfunction

    // Issue one command and trace it. vpat bit c = src_valid in post-ISSUE cycle c
    // (1 beyond bit 31); done_at = cycle in which core_done is raised (-1 never);
    // abort_at >= 0 stops tracing once that many words have been handed over.
    task automatic run_cmd(input string name, input logic [OP_W-1:0] op, input logic [1:0] mode,
                           input int len, input logic [31:0] vpat, input int done_at,
                           input int abort_at, input int max_cyc);
        @(negedge clk);
        chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        chk({name, "_idle_busy"}, 64'(busy), 64'(0));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = mode;
        cmd_len   = LEN_W'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = '0;
        chk({name, "_issue_op"}, 64'(OP_CODE), 64'(op));
        chk({name, "_issue_dv"}, 64'(din_valid), 64'(0));
        widx   = 0;
        tr_len = 0;
        for (int c = 0; c < max_cyc && c < TR_MAX; c++) begin
            @(negedge clk);
            tr_dv[c]   = din_valid;
            tr_d0[c]   = din0;
            tr_done[c] = cmd_done;
            tr_err[c]  = err;
            tr_op[c]   = OP_CODE;
            tr_len     = c + 1;
            if (cmd_done) break;
            src_valid = (c < 32) ? vpat[c] : 1'b1;
            src_data  = word_at(widx);
            core_done = (c == done_at);
            if (src_ready && src_valid) widx++;
            if (abort_at >= 0 && widx == abort_at) break;
        end
        if (abort_at < 0) begin
            src_valid = 1'b0;
            core_done = 1'b0;
            chk({name, "_done_seen"}, 64'(tr_done[tr_len-1]), 64'(1));
            chk({name, "_op_quiet"}, 64'(count_op()), 64'(0));
        end
        $display("cmd %s op=%05b mode=%0d len=%0d cycles=%0d words=%0d err=%0d",
                 name, op, mode, len, tr_len, widx, err);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_op", 64'(OP_CODE), 64'(0));
        chk("rst_dv", 64'(din_valid), 64'(0));
        chk("rst_din0", 64'(din0), 64'(0));
        chk("rst_done", 64'(cmd_done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_src_ready", 64'(src_ready), 64'(0));
        reset = 1'b0;

        // T1: three-word stream, source always ready
        words[0] = 32'hD; words[1] = 32'hD01; words[2] = 32'h5; words[3] = 32'h0;
        run_cmd("t1", OP_LD_PAR, MODE_STREAM, 3, 32'hFFFF_FFFF, -1, -1, 50);
        chk("t1_len", 64'(tr_len), 64'(5));
        chk("t1_dv_pat", 64'(pack_dv()), 64'(32'h0000_000E));
        chk("t1_w0", 64'(tr_d0[1]), 64'(32'hD));
        chk("t1_w1", 64'(tr_d0[2]), 64'(32'hD01));
        chk("t1_w2", 64'(tr_d0[3]), 64'(32'h5));
        chk("t1_words", 64'(widx), 64'(3));

        // T2: four-word stream, source stalls two cycles before the 2nd word
        words[0] = 32'hA000_0001; words[1] = 32'hA000_0002;
        words[2] = 32'hA000_0003; words[3] = 32'hA000_0004;
        run_cmd("t2", OP_LD_DATA, MODE_STREAM, 4, 32'hFFFF_FFF9, -1, -1, 50);
        chk("t2_len", 64'(tr_len), 64'(8));
        chk("t2_dv_pat", 64'(pack_dv()), 64'(32'h0000_0072));
        chk("t2_w0", 64'(tr_d0[1]), 64'(32'hA000_0001));
        chk("t2_hold", 64'(tr_d0[3]), 64'(32'hA000_0001));
        chk("t2_w1", 64'(tr_d0[4]), 64'(32'hA000_0002));
        chk("t2_w2", 64'(tr_d0[5]), 64'(32'hA000_0003));
        chk("t2_w3", 64'(tr_d0[6]), 64'(32'hA000_0004));

        // T3: HOLD 455 cycles with the source offering words the whole time
        run_cmd("t3", OP_PWM, MODE_HOLD, 455, 32'hFFFF_FFFF, -1, -1, 600);
        chk("t3_dv_count", 64'(count_dv()), 64'(455));
        chk("t3_len", 64'(tr_len), 64'(456));
        chk("t3_last_dv", 64'(tr_dv[454]), 64'(1));
        chk("t3_no_take", 64'(widx), 64'(0));
        chk("t3_din0_held", 64'(tr_d0[200]), 64'(32'hA000_0004));

        // T4: WAIT_DONE, core_done raised 40 cycles into the wait
        run_cmd("t4", OP_NTT, MODE_WAIT_DONE, 0, 32'h0, 40, -1, 200);
        chk("t4_len", 64'(tr_len), 64'(42));
        chk("t4_dv_count", 64'(count_dv()), 64'(0));
        chk("t4_err", 64'(tr_err[41]), 64'(0));

        // T5: WAIT_DONE timeout, then a WAIT command still runs with err sticky
        run_cmd("t5", OP_INTT, MODE_WAIT_DONE, 0, 32'h0, -1, -1, 200);
        chk("t5_len", 64'(tr_len), 64'(65));
        chk("t5_err_before", 64'(tr_err[63]), 64'(0));
        chk("t5_err_at", 64'(tr_err[64]), 64'(1));
        run_cmd("t5b", OP_RD, MODE_WAIT, 2, 32'hFFFF_FFFF, -1, -1, 50);
        chk("t5b_len", 64'(tr_len), 64'(3));
        chk("t5b_dv_count", 64'(count_dv()), 64'(0));
        chk("t5b_err_sticky", 64'(err), 64'(1));

        // Zero-length stream skips the payload phase
        run_cmd("z0", OP_LD_W, MODE_STREAM, 0, 32'hFFFF_FFFF, -1, -1, 20);
        chk("z0_len", 64'(tr_len), 64'(1));
        chk("z0_no_take", 64'(widx), 64'(0));

        // T6: async reset after 100 of 256 words
        run_cmd("t6", OP_LD_DATA, MODE_STREAM, 256, 32'hFFFF_FFFF, -1, 100, 400);
        chk("t6_words", 64'(widx), 64'(100));
        chk("t6_dv_before", 64'(din_valid), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("t6_op", 64'(OP_CODE), 64'(0));
        chk("t6_dv", 64'(din_valid), 64'(0));
        chk("t6_din0", 64'(din0), 64'(0));
        chk("t6_done", 64'(cmd_done), 64'(0));
        chk("t6_err", 64'(err), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_src_ready", 64'(src_ready), 64'(0));
        src_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", 64'(cmd_ready), 64'(1));

        // Sequencer works again after the abort
        run_cmd("t7", OP_LD_WINV, MODE_HOLD, 1, 32'h0, -1, -1, 20);
        chk("t7_len", 64'(tr_len), 64'(2));
        chk("t7_dv_pat", 64'(pack_dv()), 64'(32'h0000_0001));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
